// File: rtl/mmpu_line_select_sequencer_if.sv
// Command and beat-stream bundle between the instruction decoder (master)
// and the line-select sequencer (slave).
interface mmpu_line_select_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 8,
    parameter int CODE_W = 3
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_mem_op;
    logic                     cmd_col_flag;
    logic [ADDR_W-1:0]        cmd_dest_addr;
    logic [ADDR_W-1:0]        cmd_src1_addr;
    logic [ADDR_W-1:0]        cmd_src2_addr;
    logic [ADDR_W-1:0]        cmd_start;
    logic [ADDR_W-1:0]        cmd_endx;
    logic [3:0]               cmd_stride_log2;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_base;
    logic [LANES*CODE_W-1:0]  out_codes;
    logic                     out_last;

    modport master (
        output cmd_valid, cmd_mem_op, cmd_col_flag, cmd_dest_addr, cmd_src1_addr,
               cmd_src2_addr, cmd_start, cmd_endx, cmd_stride_log2, out_ready,
        input  cmd_ready, out_valid, out_base, out_codes, out_last
    );

    modport slave (
        input  cmd_valid, cmd_mem_op, cmd_col_flag, cmd_dest_addr, cmd_src1_addr,
               cmd_src2_addr, cmd_start, cmd_endx, cmd_stride_log2, out_ready,
        output cmd_ready, out_valid, out_base, out_codes, out_last
    );
endinterface

// File: rtl/mmpu_line_select_sequencer.sv
// Latches one memory-op command and sweeps lines 0..ROW_SIZE-1, emitting LANES
// vector-input mux codes per handshaked beat, then pulses done.
module mmpu_line_select_sequencer #(
    parameter int ROW_SIZE = 1024,
    parameter int ADDR_W   = 10,
    parameter int LANES    = 8,
    parameter int CODE_W   = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    mmpu_line_select_sequencer_if.slave bus,
    output logic                        busy,
    output logic                        done
);
    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic              col;
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [ADDR_W-1:0] start;
        logic [ADDR_W-1:0] endx;
        logic [ADDR_W-1:0] mask;
    } cmd_t;

    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(ROW_SIZE - LANES);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(LANES);

    // Stride is a power of two, so "offset is a multiple of stride" is a low-bit mask test.
    function automatic logic [ADDR_W-1:0] stride_mask(input logic [3:0] l2);
        logic [ADDR_W-1:0] m;
        int s;
        s = (int'(l2) >= ADDR_W) ? ADDR_W - 1 : int'(l2);
        m = '0;
        for (int b = 0; b < ADDR_W; b++) m[b] = (b < s);
        return m;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] i, input logic [ADDR_W-1:0] lo,
                                      input logic [ADDR_W-1:0] hi, input logic [ADDR_W-1:0] mask);
        logic [ADDR_W-1:0] off;
        off = (i >= lo) ? i - lo : '0;
        return (i >= lo) && (i <= hi) && ((off & mask) == '0);
    endfunction

    function automatic logic [CODE_W-1:0] line_code(input logic [ADDR_W-1:0] i, input cmd_t c);
        logic [CODE_W-1:0] code;
        code = '0;
        if (c.col) begin
            case (c.op)
                2'b00:   if (i == c.dest) code = 3'b101;
                         else if (i == c.src1) code = 3'b100;
                2'b01:   if (i == c.dest) code = 3'b101;
                         else if (i == c.src1 || i == c.src2) code = 3'b100;
                default: if (in_range(i, c.src1, c.src2, c.mask))
                             code = c.op[0] ? 3'b001 : 3'b010;
            endcase
        end else if (!in_range(i, c.start, c.endx, c.mask)) begin
            code = 3'b111;
        end else begin
            code = c.op[1] ? 3'b101 : 3'b000;
        end
        return code;
    endfunction

    function automatic logic [LANES*CODE_W-1:0] beat_codes(input logic [ADDR_W-1:0] base,
                                                           input cmd_t c);
        logic [LANES*CODE_W-1:0] codes;
        for (int k = 0; k < LANES; k++)
            codes[k*CODE_W +: CODE_W] = line_code(base + ADDR_W'(k), c);
        return codes;
    endfunction

    state_t                  state_q, state_d;
    cmd_t                    cmd_q, cmd_d, in_cmd;
    logic                    valid_q, valid_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [LANES*CODE_W-1:0] codes_q, codes_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    fire;

    assign fire = valid_q && bus.out_ready;

    always_comb begin
        in_cmd.op    = bus.cmd_mem_op;
        in_cmd.col   = bus.cmd_col_flag;
        in_cmd.dest  = bus.cmd_dest_addr;
        in_cmd.src1  = bus.cmd_src1_addr;
        in_cmd.src2  = bus.cmd_src2_addr;
        in_cmd.start = bus.cmd_start;
        in_cmd.endx  = bus.cmd_endx;
        in_cmd.mask  = stride_mask(bus.cmd_stride_log2);
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = SCAN;
            SCAN:    if (fire && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == IDLE) && !reset;
        busy          = (state_q != IDLE);
    end

    // Next beat is prepared on acceptance so a held-high out_ready sees no bubbles.
    always_comb begin
        cmd_d   = cmd_q;
        valid_d = valid_q;
        base_d  = base_q;
        codes_d = codes_q;
        last_d  = last_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.cmd_valid) begin
                cmd_d   = in_cmd;
                valid_d = 1'b1;
                base_d  = '0;
                codes_d = beat_codes('0, in_cmd);
                last_d  = (LAST_BASE == '0);
            end
        end else if (fire) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                base_d  = base_q + STEP;
                codes_d = beat_codes(base_q + STEP, cmd_q);
                last_d  = (base_q + STEP == LAST_BASE);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q   <= '0;
            valid_q <= 1'b0;
            base_q  <= '0;
            codes_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            base_q  <= base_d;
            codes_q <= codes_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_base  = base_q;
    assign bus.out_codes = codes_q;
    assign bus.out_last  = last_q;
    assign done          = done_q;
endmodule

// File: tb/tb_mmpu_line_select_sequencer.sv
// Directed bench for the line-select sequencer: small 16-line instance plus a
// default-parameter instance for the full 128-beat sweep.
module tb_mmpu_line_select_sequencer;
    localparam int AW = 4;
    localparam int LN = 4;
    localparam int CW = 3;
    localparam int RS = 16;

    logic clock = 1'b0;
    logic reset;
    logic busy, done, busy_b, done_b;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    mmpu_line_select_sequencer_if #(.ADDR_W(AW), .LANES(LN), .CODE_W(CW)) bus ();
    mmpu_line_select_sequencer #(.ROW_SIZE(RS), .ADDR_W(AW), .LANES(LN), .CODE_W(CW)) dut (
        .clock(clock), .reset(reset), .bus(bus), .busy(busy), .done(done)
    );

    mmpu_line_select_sequencer_if bus_b ();
    mmpu_line_select_sequencer dut_b (
        .clock(clock), .reset(reset), .bus(bus_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input logic col, input logic [1:0] op, input logic [3:0] dest,
                           input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] st,
                           input logic [3:0] en, input logic [3:0] sl2);
        bus.cmd_col_flag    = col;
        bus.cmd_mem_op      = op;
        bus.cmd_dest_addr   = dest;
        bus.cmd_src1_addr   = s1;
        bus.cmd_src2_addr   = s2;
        bus.cmd_start       = st;
        bus.cmd_endx        = en;
        bus.cmd_stride_log2 = sl2;
    endtask

    // Issue the pending command with out_ready held high and check all four beats.
    task automatic sweep(input string tag, input logic [11:0] e0, input logic [11:0] e1,
                         input logic [11:0] e2, input logic [11:0] e3);
        logic [11:0] e [4];
        e = '{e0, e1, e2, e3};
        check({tag, " ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check($sformatf("%s b%0d valid", tag, b), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s b%0d base", tag, b), 32'(bus.out_base), 32'(4 * b));
            check($sformatf("%s b%0d codes", tag, b), 32'(bus.out_codes), 32'(e[b]));
            check($sformatf("%s b%0d last", tag, b), 32'(bus.out_last), 32'(b == 3));
            step();
        end
        check({tag, " end valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " ready back"}, 32'(bus.cmd_ready), 32'd1);
        step();
        check({tag, " done once"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  n;
        int  bad;
        logic seen_last;

        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_cmd(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        bus_b.cmd_valid = 1'b0;
        bus_b.out_ready = 1'b0;
        bus_b.cmd_col_flag = 1'b0;
        bus_b.cmd_mem_op = 2'b00;
        bus_b.cmd_dest_addr = '0;
        bus_b.cmd_src1_addr = '0;
        bus_b.cmd_src2_addr = '0;
        bus_b.cmd_start = '0;
        bus_b.cmd_endx = '0;
        bus_b.cmd_stride_log2 = '0;
        step();
        step();
        check("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_base", 32'(bus.out_base), 32'd0);
        check("rst out_codes", 32'(bus.out_codes), 32'd0);
        check("rst out_last", 32'(bus.out_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

        set_cmd(1'b1, 2'b00, 4'd5, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        sweep("col00", 12'h100, 12'h028, 12'h000, 12'h000);
        set_cmd(1'b1, 2'b01, 4'd3, 4'd3, 4'd9, 4'd0, 4'd0, 4'd0);
        sweep("col01", 12'hA00, 12'h000, 12'h020, 12'h000);
        set_cmd(1'b1, 2'b11, 4'd0, 4'd2, 4'd13, 4'd0, 4'd0, 4'd2);
        sweep("col11s4", 12'h040, 12'h040, 12'h040, 12'h000);
        set_cmd(1'b1, 2'b10, 4'd0, 4'd2, 4'd13, 4'd0, 4'd0, 4'd2);
        sweep("col10s4", 12'h080, 12'h080, 12'h080, 12'h000);
        set_cmd(1'b1, 2'b11, 4'd0, 4'd13, 4'd2, 4'd0, 4'd0, 4'd2);
        sweep("col11empty", 12'h000, 12'h000, 12'h000, 12'h000);
        set_cmd(1'b0, 2'b10, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd0);
        sweep("row10", 12'hFFF, 12'hB6D, 12'hFFF, 12'hFFF);
        set_cmd(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd0);
        sweep("row00", 12'hFFF, 12'h000, 12'hFFF, 12'hFFF);
        set_cmd(1'b0, 2'b10, 4'd0, 4'd0, 4'd0, 4'd9, 4'd3, 4'd0);
        sweep("rowempty", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        set_cmd(1'b0, 2'b11, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15);
        sweep("rowclamp", 12'hFFD, 12'hFFF, 12'hFFD, 12'hFFF);

        // Backpressure on beat 1 with a competing command offered meanwhile.
        set_cmd(1'b1, 2'b00, 4'd5, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        bus.cmd_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        set_cmd(1'b0, 2'b10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd0);
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp c%0d base", c), 32'(bus.out_base), 32'd4);
            check($sformatf("bp c%0d codes", c), 32'(bus.out_codes), 32'h028);
            check($sformatf("bp c%0d valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp c%0d cmd_ready", c), 32'(bus.cmd_ready), 32'd0);
            check($sformatf("bp c%0d busy", c), 32'(busy), 32'd1);
            if (c < 3) step();
        end
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp b2 base", 32'(bus.out_base), 32'd8);
        check("bp b2 codes", 32'(bus.out_codes), 32'h000);
        step();
        check("bp b3 base", 32'(bus.out_base), 32'd12);
        check("bp b3 codes", 32'(bus.out_codes), 32'h000);
        check("bp b3 last", 32'(bus.out_last), 32'd1);
        step();
        check("bp done", 32'(done), 32'd1);
        check("bp idle valid", 32'(bus.out_valid), 32'd0);
        step();

        // Reset asserted while beat 2 is on the bus.
        set_cmd(1'b0, 2'b10, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd0);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        check("abort pre base", 32'(bus.out_base), 32'd8);
        reset = 1'b1;
        step();
        check("abort valid", 32'(bus.out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort cmd_ready", 32'(bus.cmd_ready), 32'd0);
        reset = 1'b0;
        step();
        check("abort post done", 32'(done), 32'd0);
        set_cmd(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd4, 4'd7, 4'd0);
        sweep("after abort", 12'hFFF, 12'h000, 12'hFFF, 12'hFFF);

        // Default parameters: 1024 lines, 8 lanes, stride 2 over the full range.
        bus_b.cmd_start = 10'd0;
        bus_b.cmd_endx = 10'd1023;
        bus_b.cmd_mem_op = 2'b10;
        bus_b.cmd_stride_log2 = 4'd1;
        check("big ready", 32'(bus_b.cmd_ready), 32'd1);
        bus_b.cmd_valid = 1'b1;
        bus_b.out_ready = 1'b1;
        step();
        bus_b.cmd_valid = 1'b0;
        n = 0;
        bad = 0;
        seen_last = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_last; cyc++) begin
            if (bus_b.out_valid) begin
                if (bus_b.out_base !== 10'(n * 8) || bus_b.out_codes !== 24'hF7DF7D) bad++;
                if (bus_b.out_last === 1'b1) seen_last = 1'b1;
                n++;
            end
            step();
        end
        check("big last seen", 32'(seen_last), 32'd1);
        check("big beats", 32'(n), 32'd128);
        check("big bad beats", 32'(bad), 32'd0);
        check("big done", 32'(done_b), 32'd1);
        step();
        check("big done once", 32'(done_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
